// File: rtl/prog_loader.sv
// prog_loader: assembles a serial byte stream into 32-bit words and writes
// them into a 512-word program RAM, starting at a given base address.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start             one-cycle load request (honoured only when idle)
//   base_addr[8:0]    first word address, captured on accepted start
//   word_count[9:0]   number of words (0..512), captured on accepted start
//   rx_data[7:0]      byte from the serial receiver
//   rx_valid          rx_data strobe, one cycle per byte
//   rx_ready          byte is accepted this cycle
//   we/waddr/wdata    program RAM write port (we pulses one cycle per word)
//   busy              load in progress
//   done              one-cycle completion pulse
//   err               sticky: a byte arrived while not ready during a load
//   checksum[31:0]    mod-2^32 sum of words written by the current/last load
module prog_loader (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [8:0]  base_addr,
  input  logic [9:0]  word_count,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        we,
  output logic [8:0]  waddr,
  output logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] checksum
);

  typedef enum logic [1:0] {IDLE, BYTE, WRITE, DONE} state_t;

  state_t      state, state_n;
  logic [8:0]  addr;
  logic [9:0]  cnt;
  logic [1:0]  bidx;
  logic [31:0] asm_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n  = state;
    rx_ready = 1'b0;
    we       = 1'b0;
    busy     = (state != IDLE);
    done     = 1'b0;
    case (state)
      IDLE:  if (start) state_n = (word_count == 10'd0) ? DONE : BYTE;
      BYTE: begin
        rx_ready = 1'b1;
        if (rx_valid && bidx == 2'd3) state_n = WRITE;
      end
      WRITE: begin
        we      = 1'b1;
        // cnt still holds the pre-decrement value here
        state_n = (cnt == 10'd1) ? DONE : BYTE;
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr     <= '0;
      cnt      <= '0;
      bidx     <= '0;
      asm_q    <= '0;
      waddr    <= '0;
      wdata    <= '0;
      checksum <= '0;
      err      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          addr     <= base_addr;
          cnt      <= word_count;
          bidx     <= '0;
          checksum <= '0;
          err      <= 1'b0;
        end
        BYTE: if (rx_valid) begin
          // big-endian: byte k lands in bits [31-8k -: 8]
          asm_q[{~bidx, 3'b000} +: 8] <= rx_data;
          bidx <= bidx + 2'd1;
          if (bidx == 2'd3) begin
            // present the word directly so WRITE needs no extra cycle
            wdata <= {asm_q[31:8], rx_data};
            waddr <= addr;
          end
        end
        WRITE: begin
          checksum <= checksum + wdata;
          addr     <= addr + 9'd1;   // wraps 511 -> 0
          cnt      <= cnt - 10'd1;
          bidx     <= '0;
          if (rx_valid) err <= 1'b1;
        end
        DONE: if (rx_valid) err <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: single word, address wrap, dropped byte,
// zero count, reset mid-load and a full 512-word load.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [8:0]  base_addr = '0;
  logic [9:0]  word_count = '0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready, we, busy, done, err;
  logic [8:0]  waddr;
  logic [31:0] wdata, checksum;

  int npass = 0;
  int ntot  = 0;

  int          wcnt = 0;
  int          acnt [512];
  logic [8:0]  la_q[$];
  logic [31:0] ld_q[$];

  prog_loader dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .word_count(word_count), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .we(we), .waddr(waddr), .wdata(wdata),
    .busy(busy), .done(done), .err(err), .checksum(checksum)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (we) begin
      wcnt++;
      acnt[waddr]++;
      la_q.push_back(waddr);
      ld_q.push_back(wdata);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntot++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else npass++;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_start(input logic [8:0] b, input logic [9:0] n);
    start = 1'b1; base_addr = b; word_count = n;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    while (!rx_ready && t < 20) begin tick(); t++; end
    if (t >= 20) chk("rdy_timeout", 32'd0, 32'd1);
    rx_valid = 1'b1; rx_data = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[31-8*k -: 8]);
  endtask

  task automatic wait_done(input string tag);
    int t = 0;
    while (!done && t < 50) begin tick(); t++; end
    chk(tag, {31'd0, done}, 32'd1);
  endtask

  initial begin
    int w0;
    logic [31:0] sum, d;
    logic [31:0] words [512];
    int bad;

    foreach (acnt[i]) acnt[i] = 0;
    #12;
    // reset values
    chk("rst_ready", {31'd0, rx_ready}, 0);
    chk("rst_we",    {31'd0, we}, 0);
    chk("rst_waddr", {23'd0, waddr}, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_busy",  {31'd0, busy}, 0);
    chk("rst_done",  {31'd0, done}, 0);
    chk("rst_err",   {31'd0, err}, 0);
    chk("rst_csum",  checksum, 0);
    @(posedge clk); #1; rst = 1'b0;
    tick();

    // single word
    do_start(9'h010, 10'd1);
    chk("sw_busy", {31'd0, busy}, 1);
    send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
    chk("sw_we",    {31'd0, we}, 1);
    chk("sw_waddr", {23'd0, waddr}, 32'h010);
    chk("sw_wdata", wdata, 32'hDEADBEEF);
    tick();
    chk("sw_done",  {31'd0, done}, 1);
    chk("sw_we_off", {31'd0, we}, 0);
    chk("sw_csum",  checksum, 32'hDEADBEEF);
    tick();
    chk("sw_idle",  {31'd0, busy}, 0);
    chk("sw_wcnt",  wcnt, 1);
    chk("sw_hold",  wdata, 32'hDEADBEEF);

    // address wrap
    la_q.delete(); ld_q.delete();
    do_start(9'h1FF, 10'd2);
    send_word(32'h00000001);
    send_word(32'h00000002);
    wait_done("wr_done");
    chk("wr_n",    la_q.size(), 2);
    if (la_q.size() == 2) begin
      chk("wr_a0", {23'd0, la_q[0]}, 32'h1FF);
      chk("wr_a1", {23'd0, la_q[1]}, 32'h000);
    end
    chk("wr_csum", checksum, 32'h3);

    // dropped byte in WRITE; start while busy must be ignored
    tick(); tick();
    la_q.delete(); ld_q.delete();
    do_start(9'h020, 10'd2);
    send_word(32'h11223344);
    rx_valid = 1'b1; rx_data = 8'hAA;   // lands in the WRITE cycle
    tick();
    rx_valid = 1'b0;
    chk("dr_err", {31'd0, err}, 1);
    do_start(9'h000, 10'd0);             // ignored: not idle
    chk("dr_nostart", {31'd0, done}, 0);
    send_word(32'h55667788);
    wait_done("dr_done");
    chk("dr_n", ld_q.size(), 2);
    if (ld_q.size() == 2) chk("dr_w1", ld_q[1], 32'h55667788);
    chk("dr_csum", checksum, 32'h6688AACC);
    tick();
    chk("dr_err_sticky", {31'd0, err}, 1);

    // zero count; start clears err
    w0 = wcnt;
    do_start(9'h055, 10'd0);
    chk("zc_busy", {31'd0, busy}, 1);
    chk("zc_done", {31'd0, done}, 1);
    chk("zc_err",  {31'd0, err}, 0);
    tick();
    chk("zc_busy2", {31'd0, busy}, 0);
    chk("zc_done2", {31'd0, done}, 0);
    chk("zc_nowe", wcnt, w0);

    // reset mid-load: abort with no further write
    do_start(9'h100, 10'd5);
    send_word(32'hA0A0A0A0); send_word(32'hB1B1B1B1); send_word(32'hC2C2C2C2);
    send_byte(8'h01); send_byte(8'h02);
    w0 = wcnt;
    #2 rst = 1'b1; #1;
    chk("rm_busy",  {31'd0, busy}, 0);
    chk("rm_ready", {31'd0, rx_ready}, 0);
    chk("rm_waddr", {23'd0, waddr}, 0);
    chk("rm_wdata", wdata, 0);
    chk("rm_csum",  checksum, 0);
    tick(); rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      rx_valid = 1'b1; rx_data = 8'h33;   // idle: ignored, no err
      tick();
    end
    rx_valid = 1'b0;
    chk("rm_nowe", wcnt, w0);
    chk("rm_err",  {31'd0, err}, 0);
    chk("rm_idle", {31'd0, busy}, 0);

    // full load; first byte collides with start and must not be taken
    foreach (acnt[i]) acnt[i] = 0;
    w0 = wcnt;
    sum = 0;
    for (int i = 0; i < 512; i++) begin
      d = $urandom; words[i] = d; sum = sum + d;
    end
    rx_valid = 1'b1; rx_data = 8'hFF;
    do_start(9'h0AB, 10'd512);
    rx_valid = 1'b0;
    for (int i = 0; i < 512; i++) send_word(words[i]);
    wait_done("fl_done");
    chk("fl_wcnt", wcnt - w0, 512);
    bad = 0;
    foreach (acnt[i]) if (acnt[i] != 1) bad++;
    chk("fl_cover", bad, 0);
    chk("fl_last",  wdata, words[511]);
    chk("fl_csum",  checksum, sum);
    chk("fl_err",   {31'd0, err}, 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset, with ports named clk and rst.
REQ-002 Port clk SHALL be an input, 1 bit wide: the system clock; all state updates on its rising edge.
REQ-003 Port rst SHALL be an input, 1 bit wide: asynchronous, active-high reset.
REQ-004 Port start SHALL be an input, 1 bit wide: a one-cycle request to begin a load; sampled only in IDLE.
REQ-005 Port base_addr SHALL be an input, 9 bits wide: the first word address; captured on an accepted start.
REQ-006 Port word_count SHALL be an input, 10 bits wide: the number of words to load (0..512); captured on an accepted start.
REQ-007 Port rx_data SHALL be an input, 8 bits wide: a byte from the serial receiver.
REQ-008 Port rx_valid SHALL be an input, 1 bit wide: rx_data is valid this cycle (one-cycle strobe per byte).
REQ-009 Port rx_ready SHALL be an output, 1 bit wide: the block accepts a byte this cycle.
REQ-010 Port we SHALL be an output, 1 bit wide: the program RAM write enable.
REQ-011 Port waddr SHALL be an output, 9 bits wide: the program RAM word address.
REQ-012 Port wdata SHALL be an output, 32 bits wide: the program RAM write data.
REQ-013 Port busy SHALL be an output, 1 bit wide: a load is in progress (state is not IDLE).
REQ-014 Port done SHALL be an output, 1 bit wide: a one-cycle pulse when the load completes.
REQ-015 Port err SHALL be an output, 1 bit wide: a sticky flag set when a byte is dropped; cleared on an accepted start.
REQ-016 Port checksum SHALL be an output, 32 bits wide: the modulo-2^32 sum of all words written in the current or last load.

Function
REQ-017 The block SHALL implement exactly the states IDLE, BYTE, WRITE and DONE.
REQ-018 IDLE: on start=1, capture base_addr and word_count, clear the byte index, checksum and err, then go to BYTE; if the captured word_count is 0, go to DONE instead.
REQ-019 BYTE: rx_ready=1; a byte is accepted when rx_valid=1.
REQ-020 Byte order SHALL be big-endian: accepted byte k (k=0..3) loads assembly bits [31-8k:24-8k].
REQ-021 On acceptance of byte 3 in cycle N, the block SHALL enter WRITE in cycle N+1 with we=1, waddr set to the current address, and wdata set to the assembled word.
REQ-022 WRITE SHALL last exactly one cycle: rx_ready=0, checksum += wdata, address += 1, remaining count -= 1.
REQ-023 From WRITE, the block SHALL go to DONE if the remaining count reaches 0, otherwise back to BYTE with the byte index cleared.
REQ-024 The address SHALL wrap from 511 to 0 without error.
REQ-025 DONE SHALL last one cycle with done=1, then return to IDLE; busy=1 in DONE.
REQ-026 If rx_valid=1 while rx_ready=0 in any state other than IDLE, the byte SHALL be dropped and err set to 1.
REQ-027 rx_valid in IDLE SHALL be ignored without setting err.
REQ-028 start SHALL be ignored when the state is not IDLE.
REQ-029 If start and rx_valid are asserted in the same IDLE cycle, the byte SHALL NOT be accepted.
REQ-030 In all states other than WRITE, we=0 and wdata/waddr SHALL hold their last values.
REQ-031 checksum and err SHALL remain valid after DONE until the next accepted start.

Reset
REQ-032 On rst=1, regardless of the clock, the block SHALL go to IDLE with rx_ready=0, we=0, waddr=0, wdata=0, busy=0, done=0, err=0, checksum=0, and byte index and count cleared.
REQ-033 A reset asserted mid-load SHALL abort the load with no further write, including when a write is pending in WRITE.
REQ-034 After reset deasserts, the block SHALL require a new start before accepting any byte.

Verification
REQ-035 Single word: start with base_addr=0x010 and word_count=1, then bytes 0xDE,0xAD,0xBE,0xEF -> exactly one we pulse, one cycle after the 4th byte, with waddr=0x010 and wdata=0xDEADBEEF; done pulses the next cycle; checksum=0xDEADBEEF.
REQ-036 Wrap: base_addr=0x1FF, word_count=2, words 0x00000001 and 0x00000002 -> writes to addresses 0x1FF then 0x000; checksum=0x00000003.
REQ-037 Drop: send a byte in the WRITE cycle -> err=1, the byte is not assembled, and the next accepted byte is treated as byte 0 of the next word.
REQ-038 Zero count: start with word_count=0 -> no we; done pulses on the cycle after start; busy is high for one cycle.
REQ-039 Reset mid-load: assert rst after 2 bytes of word 3 -> no we afterwards, all outputs at reset values, and start is required to resume.
REQ-040 Full load: word_count=512 of random data -> 512 writes covering every address exactly once, and checksum equals the reference sum.
